// File: rtl/dpwm_seq_pkg.sv
// Shared constants for the DPWM supervisory sequencer: state codes, fault bit
// positions and the default fault-filter depth.
package dpwm_seq_pkg;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StArm     = 3'd1;
    localparam logic [2:0] StRamp    = 3'd2;
    localparam logic [2:0] StRun     = 3'd3;
    localparam logic [2:0] StFault   = 3'd4;
    localparam logic [2:0] StHoldoff = 3'd5;
    localparam logic [2:0] StLockout = 3'd6;

    localparam int unsigned FLT_OC = 0;
    localparam int unsigned FLT_OT = 1;
    localparam int unsigned FLT_UV = 2;

    localparam int unsigned FAULT_FILT_DEF = 4;

endpackage

// File: rtl/fault_filter.sv
// Consecutive-sample over-limit qualifier; trip pulses combinationally on the
// strobe that completes the run so the sequencer can react on that same edge.
module fault_filter
    import dpwm_seq_pkg::*;
#(
    parameter int unsigned M          = 12,
    parameter int unsigned FAULT_FILT = FAULT_FILT_DEF
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       active,
    input  logic       meas_valid,
    input  logic [M:0] err,
    input  logic [M:0] lim,
    output logic       trip
);

    localparam int unsigned   CW      = $clog2(FAULT_FILT + 1);
    localparam logic [CW-1:0] CntMax  = CW'(FAULT_FILT);
    localparam logic [CW-1:0] CntTrip = CW'(FAULT_FILT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          over;

    assign over = err > lim;

    always_comb begin
        cnt_d = cnt_q;
        if (!active) begin
            cnt_d = '0;
        end else if (meas_valid) begin
            if (!over) begin
                cnt_d = '0;
            end else if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign trip = active && meas_valid && over && (cnt_q == CntTrip);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dpwm_sequencer.sv
// Supervisory sequencer for the DPWM stage: arm, soft-start ramp, run, fault
// shutdown with timed retry, and lockout. All outputs are registered.
module dpwm_sequencer
    import dpwm_seq_pkg::*;
#(
    parameter int unsigned M            = 12,
    parameter int unsigned RAMP_DIV     = 16,
    parameter int unsigned ARM_CYCLES   = 1024,
    parameter int unsigned FAULT_FILT   = FAULT_FILT_DEF,
    parameter int unsigned RETRY_CYCLES = 50000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       clear_fault,
    input  logic [9:0] duty_target,
    input  logic [9:0] maxcount,
    input  logic       meas_valid,
    input  logic [M:0] iout_err,
    input  logic [M:0] temp_err,
    input  logic [M:0] vin_err,
    input  logic [M:0] ocp_lim,
    input  logic [M:0] otp_lim,
    input  logic [M:0] uvp_lim,
    output logic       dpwm_en,
    output logic       dpwm_rst,
    output logic [9:0] duty_cmd,
    output logic [2:0] state,
    output logic [2:0] fault_code,
    output logic [1:0] retry_cnt
);

    localparam int unsigned TMax01 = (ARM_CYCLES > RETRY_CYCLES) ? ARM_CYCLES : RETRY_CYCLES;
    localparam int unsigned TMax   = (TMax01 > RAMP_DIV) ? TMax01 : RAMP_DIV;
    localparam int unsigned TW     = (TMax > 1) ? $clog2(TMax) : 1;

    localparam logic [TW-1:0] ArmLast   = TW'(ARM_CYCLES - 1);
    localparam logic [TW-1:0] RetryLast = TW'(RETRY_CYCLES - 1);
    localparam logic [TW-1:0] DivLast   = TW'(RAMP_DIV - 1);
    localparam logic [1:0]    RetryMax  = 2'(MAX_RETRY);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] div_q, div_d;
    logic [1:0]    retry_q, retry_d;
    logic [2:0]    fault_q, fault_d;
    logic [9:0]    duty_q, duty_d, duty_nxt;
    logic          en_q, en_d, rst_q, rst_d;
    logic [9:0]    tgt;
    logic [2:0]    trip;
    logic          active, step, run_d;

    assign tgt    = (maxcount == 10'd0) ? 10'd0 :
                    (duty_target < maxcount) ? duty_target : maxcount - 10'd1;
    assign active = (state_q == StArm) || (state_q == StRamp) || (state_q == StRun);
    assign step   = (div_q == DivLast);

    fault_filter #(.M(M), .FAULT_FILT(FAULT_FILT)) u_flt_oc (
        .CLOCK_50(CLOCK_50), .reset(reset), .active(active), .meas_valid(meas_valid),
        .err(iout_err), .lim(ocp_lim), .trip(trip[FLT_OC])
    );
    fault_filter #(.M(M), .FAULT_FILT(FAULT_FILT)) u_flt_ot (
        .CLOCK_50(CLOCK_50), .reset(reset), .active(active), .meas_valid(meas_valid),
        .err(temp_err), .lim(otp_lim), .trip(trip[FLT_OT])
    );
    fault_filter #(.M(M), .FAULT_FILT(FAULT_FILT)) u_flt_uv (
        .CLOCK_50(CLOCK_50), .reset(reset), .active(active), .meas_valid(meas_valid),
        .err(vin_err), .lim(uvp_lim), .trip(trip[FLT_UV])
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            div_q   <= '0;
            retry_q <= '0;
            fault_q <= '0;
            duty_q  <= '0;
            en_q    <= 1'b0;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            div_q   <= div_d;
            retry_q <= retry_d;
            fault_q <= fault_d;
            duty_q  <= duty_d;
            en_q    <= en_d;
            rst_q   <= rst_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        div_d    = '0;
        retry_d  = retry_q;
        fault_d  = fault_q;
        duty_nxt = duty_q;
        case (state_q)
            StIdle: begin
                timer_d = '0;
                if (clear_fault) begin
                    fault_d = '0;
                    retry_d = '0;
                end
                if (start) state_d = StArm;
            end
            StArm: begin
                if (timer_q == ArmLast) begin
                    timer_d = '0;
                    state_d = StRamp;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StRamp: begin
                div_d = step ? '0 : div_q + TW'(1);
                if (duty_q >= tgt) begin
                    duty_nxt = tgt;
                    state_d  = StRun;
                end else if (step) begin
                    duty_nxt = duty_q + 10'd1;
                    if (duty_nxt >= tgt) state_d = StRun;
                end
            end
            StRun: begin
                div_d = step ? '0 : div_q + TW'(1);
                if (step && duty_q < tgt) duty_nxt = duty_q + 10'd1;
                else if (step && duty_q > tgt) duty_nxt = duty_q - 10'd1;
            end
            StFault: begin
                timer_d = '0;
                if (retry_q < RetryMax) begin
                    retry_d = retry_q + 2'd1;
                    state_d = StHoldoff;
                end else begin
                    state_d = StLockout;
                end
            end
            StHoldoff: begin
                if (timer_q == RetryLast) begin
                    timer_d = '0;
                    state_d = start ? StArm : StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StLockout: begin
                if (clear_fault) begin
                    fault_d = '0;
                    retry_d = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StFault;
        endcase
        // A trip outranks a dropped run request, which outranks timers and slewing.
        if (active) begin
            if (|trip) begin
                state_d = StFault;
                fault_d = fault_q | trip;
            end else if (!start) begin
                state_d = StIdle;
            end
        end
    end

    always_comb begin
        run_d  = (state_d == StRamp) || (state_d == StRun);
        en_d   = run_d;
        rst_d  = !run_d;
        duty_d = run_d ? duty_nxt : 10'd0;
    end

    assign dpwm_en    = en_q;
    assign dpwm_rst   = rst_q;
    assign duty_cmd   = duty_q;
    assign state      = state_q;
    assign fault_code = fault_q;
    assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_dpwm_sequencer.sv
// Directed bench for dpwm_sequencer with small timing parameters so every
// phase (arm, ramp, slew, filter, retry, lockout) is reached quickly.
module tb_dpwm_sequencer;

    logic        CLOCK_50;
    logic        reset, start, clear_fault, meas_valid;
    logic [9:0]  duty_target, maxcount;
    logic [12:0] iout_err, temp_err, vin_err, ocp_lim, otp_lim, uvp_lim;
    logic        dpwm_en, dpwm_rst;
    logic [9:0]  duty_cmd;
    logic [2:0]  state, fault_code;
    logic [1:0]  retry_cnt;

    int ncmp = 0;
    int nerr = 0;

    dpwm_sequencer #(
        .M(12), .RAMP_DIV(2), .ARM_CYCLES(8), .FAULT_FILT(3),
        .RETRY_CYCLES(20), .MAX_RETRY(2)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .clear_fault(clear_fault),
        .duty_target(duty_target), .maxcount(maxcount), .meas_valid(meas_valid),
        .iout_err(iout_err), .temp_err(temp_err), .vin_err(vin_err),
        .ocp_lim(ocp_lim), .otp_lim(otp_lim), .uvp_lim(uvp_lim),
        .dpwm_en(dpwm_en), .dpwm_rst(dpwm_rst), .duty_cmd(duty_cmd),
        .state(state), .fault_code(fault_code), .retry_cnt(retry_cnt)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic strobe();
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int unsigned pat [5];
        pat = '{100, 100, 50, 100, 100};
        reset = 1'b1; start = 1'b0; clear_fault = 1'b0; meas_valid = 1'b0;
        duty_target = '0; maxcount = '0;
        iout_err = '0; temp_err = '0; vin_err = '0;
        ocp_lim = 13'd1000; otp_lim = 13'd1000; uvp_lim = 13'd1000;
        tick(); tick();
        reset = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_en", dpwm_en, 0);
        chk("rst_dpwm_rst", dpwm_rst, 1);
        chk("rst_duty", duty_cmd, 0);
        chk("rst_fault", fault_code, 0);
        chk("rst_retry", retry_cnt, 0);

        // Nominal start: 8 clocks of ARM, then 1 count per 2 clocks up to 10.
        start = 1'b1; maxcount = 10'd357; duty_target = 10'd10;
        tick();
        chk("arm_state", state, 1);
        chk("arm_rst", dpwm_rst, 1);
        chk("arm_en", dpwm_en, 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("arm_hold", state, 1);
            chk("arm_hold_rst", dpwm_rst, 1);
        end
        tick();
        chk("ramp_state", state, 2);
        chk("ramp_en", dpwm_en, 1);
        chk("ramp_rst", dpwm_rst, 0);
        chk("ramp_duty0", duty_cmd, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("ramp_mid_duty", duty_cmd, k - 1);
            chk("ramp_mid_state", state, 2);
            tick();
            chk("ramp_duty", duty_cmd, k);
            chk("ramp_run_state", state, (k == 10) ? 3 : 2);
        end

        // Clamp to maxcount-1 and slew up, then slew down.
        duty_target = 10'd400; maxcount = 10'd250;
        repeat (477) tick();
        chk("slew_up_248", duty_cmd, 248);
        tick();
        chk("slew_up_249", duty_cmd, 249);
        repeat (4) tick();
        chk("clamp_hold", duty_cmd, 249);
        chk("clamp_state", state, 3);
        duty_target = 10'd5;
        tick();
        chk("slew_dn_first", duty_cmd, 249);
        tick();
        chk("slew_dn_step", duty_cmd, 248);
        repeat (486) tick();
        chk("slew_dn_5", duty_cmd, 5);
        repeat (4) tick();
        chk("slew_dn_hold", duty_cmd, 5);

        // Filter: a broken run of over-limit strobes must not trip.
        ocp_lim = 13'd90;
        for (int i = 0; i < 5; i++) begin
            iout_err = 13'(pat[i]);
            strobe();
            chk("filt_notrip", state, 3);
        end
        chk("filt_en_on", dpwm_en, 1);
        iout_err = 13'd100;
        strobe();
        chk("trip_state", state, 4);
        chk("trip_en", dpwm_en, 0);
        chk("trip_duty", duty_cmd, 0);
        chk("trip_code", fault_code, 1);
        chk("trip_rst", dpwm_rst, 1);

        // Retry twice with OC held, then lockout.
        tick();
        chk("retry1_state", state, 5);
        chk("retry1_cnt", retry_cnt, 1);
        repeat (19) tick();
        chk("holdoff1_hold", state, 5);
        tick();
        chk("rearm1", state, 1);
        strobe(); strobe();
        chk("rearm1_notrip", state, 1);
        strobe();
        chk("trip2_state", state, 4);
        tick();
        chk("retry2_state", state, 5);
        chk("retry2_cnt", retry_cnt, 2);
        repeat (20) tick();
        chk("rearm2", state, 1);
        strobe(); strobe(); strobe();
        chk("trip3_state", state, 4);
        tick();
        chk("lockout_state", state, 6);
        chk("lockout_retry", retry_cnt, 2);
        chk("lockout_en", dpwm_en, 0);
        start = 1'b0;
        tick();
        chk("lockout_start0", state, 6);
        start = 1'b1;
        tick();
        chk("lockout_start1", state, 6);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("clear_state", state, 0);
        chk("clear_code", fault_code, 0);
        chk("clear_retry", retry_cnt, 0);

        // OT trip on the same edge as start dropping: trip wins.
        iout_err = '0;
        tick();
        chk("ot_arm", state, 1);
        temp_err = 13'd2000;
        strobe(); strobe();
        chk("ot_pre", state, 1);
        start = 1'b0;
        strobe();
        chk("ot_vs_stop_state", state, 4);
        chk("ot_code", fault_code, 2);
        tick();
        chk("ot_holdoff", state, 5);
        chk("ot_retry", retry_cnt, 1);
        repeat (20) tick();
        chk("ot_idle", state, 0);
        chk("ot_code_kept", fault_code, 2);
        temp_err = '0;
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("idle_clear_code", fault_code, 0);
        chk("idle_clear_retry", retry_cnt, 0);

        // Reset mid-ramp.
        start = 1'b1;
        tick();
        repeat (8) tick();
        chk("rr_ramp", state, 2);
        repeat (8) tick();
        chk("rr_duty4", duty_cmd, 4);
        reset = 1'b1;
        tick();
        chk("rr_duty", duty_cmd, 0);
        chk("rr_state", state, 0);
        chk("rr_en", dpwm_en, 0);
        chk("rr_rst", dpwm_rst, 1);
        reset = 1'b0; start = 1'b0;
        tick();

        // UV during ARM, start low at holdoff expiry.
        vin_err = 13'd2000;
        start = 1'b1;
        tick();
        chk("uv_arm", state, 1);
        strobe(); strobe(); strobe();
        chk("uv_trip", state, 4);
        chk("uv_code", fault_code, 4);
        start = 1'b0;
        tick();
        chk("uv_holdoff", state, 5);
        chk("uv_retry", retry_cnt, 1);
        repeat (19) tick();
        chk("uv_holdoff_hold", state, 5);
        tick();
        chk("uv_idle", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/dpwm_sequencer.md
Name: dpwm_sequencer

Overview:
- Supervisory controller for the DPWM power stage.
- Sequences the converter through arm, soft-start ramp, run, fault shutdown, timed retry and lockout.
- Qualifies the ADC error measurements (Iout, Temp, Vin) with consecutive-sample filters.
- Sits between the ADC reader and the DPWM. Drives the DPWM enable, the DPWM counter reset and the slew-limited duty command, and replaces ad-hoc soft-start and disable signals in the top level.

Parameters:
- M, 12: ADC error MSB index; error and limit inputs are M+1 bits.
- RAMP_DIV, 16: clocks per 1-count duty step (ramp and run slew).
- ARM_CYCLES, 1024: clocks DPWM is held in reset with outputs off before the ramp.
- FAULT_FILT, 4: consecutive over-limit samples that declare a fault.
- RETRY_CYCLES, 50000: hold-off clocks after a fault before re-arming.
- MAX_RETRY, 3: automatic retries before lockout.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; dominates every other input.
- start  in  1  level run request.
- clear_fault  in  1  single-cycle pulse; releases LOCKOUT and clears sticky faults.
- duty_target  in  10  requested duty in counts.
- maxcount  in  10  current DPWM period count.
- meas_valid  in  1  one-cycle strobe; the error inputs are valid this cycle.
- iout_err, temp_err, vin_err  in  M+1  unsigned error magnitudes from the ADC reader.
- ocp_lim, otp_lim, uvp_lim  in  M+1  unsigned trip thresholds.
- dpwm_en  out  1  DPWM enable.
- dpwm_rst  out  1  active-high DPWM counter reset.
- duty_cmd  out  10  duty count applied to the DPWM.
- state  out  3  current state encoding.
- fault_code  out  3  sticky fault bits: [0]=OC, [1]=OT, [2]=UV.
- retry_cnt  out  2  retries used since the last clear.

Behaviour:
- Outputs:
  - All outputs are registered.
  - Reset values: state=IDLE, dpwm_en=0, dpwm_rst=1, duty_cmd=0, fault_code=0, retry_cnt=0; all filter and timer counters are 0.
- Target clamping: tgt = min(duty_target, maxcount-1), evaluated every cycle. maxcount=0 gives tgt=0.
- State encodings: IDLE=0, ARM=1, RAMP=2, RUN=3, FAULT=4, HOLDOFF=5, LOCKOUT=6. Code 7 is illegal and goes to FAULT on the next clock.
- IDLE:
  - dpwm_en=0, dpwm_rst=1, duty_cmd=0.
  - start=1 goes to ARM; timer is loaded to 0.
- ARM:
  - dpwm_en=0, dpwm_rst=1.
  - After ARM_CYCLES clocks goes to RAMP.
- RAMP:
  - dpwm_rst=0, dpwm_en=1.
  - Every RAMP_DIV clocks duty_cmd increments by 1.
  - When duty_cmd >= tgt: duty_cmd=tgt, then go to RUN. This covers tgt dropping below duty_cmd, which snaps down on the same edge.
- RUN:
  - dpwm_en=1.
  - Every RAMP_DIV clocks duty_cmd moves 1 count toward tgt; it holds when equal.
- start=0 in ARM, RAMP or RUN: go to IDLE next clock. duty_cmd=0, dpwm_en=0 and dpwm_rst=1 on that same edge.
- Fault filters:
  - There are three filters. Each is active only in ARM, RAMP and RUN.
  - On meas_valid, a filter's counter increments if err > lim and resets to 0 otherwise.
  - It saturates at FAULT_FILT.
  - Counters clear on entry to IDLE or FAULT.
- Trip:
  - The meas_valid edge that brings any counter to FAULT_FILT moves state to FAULT on that same edge.
  - On that edge dpwm_en=0 and duty_cmd=0, so the DPWM is off 1 clock after the qualifying strobe.
  - The matching fault_code bits are OR-set; several bits may set together.
- FAULT (lasts one clock):
  - dpwm_rst=1.
  - If retry_cnt < MAX_RETRY: retry_cnt++ and go to HOLDOFF.
  - Otherwise go to LOCKOUT.
- HOLDOFF:
  - Outputs are off.
  - After RETRY_CYCLES clocks: go to ARM if start=1, else IDLE.
  - fault_code is kept.
- LOCKOUT:
  - Outputs are off.
  - Only clear_fault goes to IDLE, clearing fault_code and retry_cnt.
- clear_fault in IDLE clears fault_code and retry_cnt. It is ignored in all other states.
- Priority on the same edge: reset > trip > start=0 > timer expiry or slew step.
- retry_cnt is not cleared by entering RUN; only reset or clear_fault clear it.
- Reset asserted mid-ramp or mid-run forces the reset values on the next edge.
- Width rules:
  - Duty arithmetic is 10-bit unsigned.
  - Timers are sized with $clog2 of the largest of ARM_CYCLES, RETRY_CYCLES and RAMP_DIV.
  - No wrap is permitted; all counters saturate or reload.

Decomposition:
- Package dpwm_seq_pkg holds:
  - state localparams;
  - fault bit indices FLT_OC, FLT_OT, FLT_UV;
  - the FAULT_FILT default.
- Sub-module fault_filter (params M, FAULT_FILT):
  - inputs: CLOCK_50, reset, active, meas_valid, err, lim;
  - output: trip, a one-cycle pulse.
  - It is instantiated three times.

Test Plan (bench params: RAMP_DIV=2, ARM_CYCLES=8, FAULT_FILT=3, RETRY_CYCLES=20, MAX_RETRY=2):
- Nominal start: reset, then start=1, maxcount=357, duty_target=10. ARM lasts 8 clocks with dpwm_rst=1. duty_cmd then rises 0→10 at 1 count per 2 clocks, and state=RUN exactly when duty_cmd=10.
- Clamp and slew: in RUN, set duty_target=400 with maxcount=250. duty_cmd slews to 249 and holds. Then set duty_target=5: duty_cmd decrements 1 per 2 clocks to 5.
- Filter: iout_err=100, ocp_lim=90.
  - Strobe pattern over, over, under, over, over gives no trip.
  - A third consecutive over-limit strobe gives FAULT on that edge, dpwm_en=0 one clock after the strobe, and fault_code=3'b001.
- Retry/lockout: hold OC active. Retries occur with retry_cnt 1, then 2. The third trip enters LOCKOUT, where start toggling has no effect. clear_fault goes to IDLE with fault_code=0 and retry_cnt=0.
- Simultaneous events:
  - start=0 on the same edge as a qualifying OT strobe gives FAULT (not IDLE) and fault_code=3'b010.
  - reset mid-RAMP (duty_cmd=4) gives duty_cmd=0 and state=IDLE next clock.
- UV during ARM: vin_err > uvp_lim for 3 strobes trips from ARM, fault_code=3'b100. If start=0 at HOLDOFF expiry, the state goes to IDLE.
